// File: rtl/dut.sv
// Streaming predicate unit: compares or tests two signed column elements per cycle and
// emits a registered mask bit, with an optional running ANY/ALL reduction.
module dut #(
    parameter int NUM_SIZE      = 32,
    parameter int CMD_SIZE_LOG2 = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic signed [NUM_SIZE-1:0]      in1,
    input  logic signed [NUM_SIZE-1:0]      in2,
    input  logic [(2**CMD_SIZE_LOG2)-1:0]   cmd,
    output logic                            out
);

    localparam int CMD_W = 2**CMD_SIZE_LOG2;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_EQ    = 4'd1;
    localparam logic [3:0] OP_NE    = 4'd2;
    localparam logic [3:0] OP_LT    = 4'd3;
    localparam logic [3:0] OP_LE    = 4'd4;
    localparam logic [3:0] OP_GT    = 4'd5;
    localparam logic [3:0] OP_GE    = 4'd6;
    localparam logic [3:0] OP_ISNA  = 4'd7;
    localparam logic [3:0] OP_NOTNA = 4'd8;
    localparam logic [3:0] OP_ANDNZ = 4'd9;
    localparam logic [3:0] OP_NEG   = 4'd10;
    localparam logic [3:0] OP_ZERO  = 4'd11;
    localparam logic [3:0] OP_ABSLT = 4'd12;

    localparam logic [1:0] MODE_ANY = 2'b01;
    localparam logic [1:0] MODE_ALL = 2'b10;

    localparam logic [NUM_SIZE-1:0] NA_VALUE = {1'b1, {(NUM_SIZE-1){1'b0}}};

    logic [3:0]          w_op;
    logic [1:0]          w_mode;
    logic                w_invert;
    logic                w_restart;
    logic                w_na1;
    logic                w_na2;
    logic                w_any_na;
    logic [NUM_SIZE-1:0] w_mag1;
    logic [NUM_SIZE-1:0] w_mag2;
    logic                w_raw;
    logic                w_r;
    logic                w_any_next;
    logic                w_all_next;
    logic                w_out_next;

    logic                r_out;
    logic                r_acc_any;
    logic                r_acc_all;

    assign w_op      = cmd[3:0];
    assign w_mode    = cmd[5:4];
    assign w_invert  = cmd[6];
    assign w_restart = cmd[7];

    generate
        if (CMD_W > 8) begin : g_cmd_hi
            logic w_unused_cmd_hi;
            assign w_unused_cmd_hi = ^cmd[CMD_W-1:8];
        end
    endgenerate

    assign w_na1    = (in1 == NA_VALUE);
    assign w_na2    = (in2 == NA_VALUE);
    assign w_any_na = w_na1 | w_na2;

    // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
    assign w_mag1 = in1[NUM_SIZE-1] ? (~in1 + 1'b1) : in1;
    assign w_mag2 = in2[NUM_SIZE-1] ? (~in2 + 1'b1) : in2;

    always_comb begin
        w_raw = 1'b0;
        case (w_op)
            OP_NOP:   w_raw = 1'b0;
            OP_EQ:    w_raw = !w_any_na && (in1 == in2);
            OP_NE:    w_raw = w_any_na || (in1 != in2);
            OP_LT:    w_raw = !w_any_na && (in1 <  in2);
            OP_LE:    w_raw = !w_any_na && (in1 <= in2);
            OP_GT:    w_raw = !w_any_na && (in1 >  in2);
            OP_GE:    w_raw = !w_any_na && (in1 >= in2);
            OP_ISNA:  w_raw = w_na1;
            OP_NOTNA: w_raw = !w_na1;
            OP_ANDNZ: w_raw = ((in1 & in2) != '0);
            OP_NEG:   w_raw = !w_na1 && in1[NUM_SIZE-1];
            OP_ZERO:  w_raw = (in1 == '0);
            OP_ABSLT: w_raw = !w_any_na && (w_mag1 < w_mag2);
            default:  w_raw = 1'b0;
        endcase
    end

    assign w_r = w_raw ^ w_invert;

    // Restart seeds the accumulator with its identity so the current element still counts.
    always_comb begin
        w_any_next = r_acc_any;
        w_all_next = r_acc_all;
        w_out_next = w_r;
        case (w_mode)
            MODE_ANY: begin
                w_any_next = (w_restart ? 1'b0 : r_acc_any) | w_r;
                w_out_next = w_any_next;
            end
            MODE_ALL: begin
                w_all_next = (w_restart ? 1'b1 : r_acc_all) & w_r;
                w_out_next = w_all_next;
            end
            default: begin
                w_out_next = w_r;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out     <= 1'b0;
            r_acc_any <= 1'b0;
            r_acc_all <= 1'b1;
        end else begin
            r_out     <= w_out_next;
            r_acc_any <= w_any_next;
            r_acc_all <= w_all_next;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_dut.sv
// Self-checking bench for dut: directed spec cases plus random stimulus against
// an arithmetic reference model of predicates and ANY/ALL reductions.
module tb_dut;

    localparam int NA_V = 32'h8000_0000;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [31:0] in1;
    logic signed [31:0] in2;
    logic [7:0]         cmd;
    logic               out;

    int  errors = 0;
    int  checks = 0;
    bit  m_any  = 1'b0;
    bit  m_all  = 1'b1;

    dut #(.NUM_SIZE(32), .CMD_SIZE_LOG2(3)) u_dut (
        .clk   (clk),
        .reset (reset),
        .in1   (in1),
        .in2   (in2),
        .cmd   (cmd),
        .out   (out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mk(input logic [3:0] op, input logic [1:0] mode,
                                      input bit inv, input bit rst);
        return {rst, inv, mode, op};
    endfunction

    function automatic bit model_raw(input int op, input int ai, input int bi);
        longint a, b, ma, mb;
        bit na1, na2;
        a   = longint'(ai);
        b   = longint'(bi);
        na1 = (ai == NA_V);
        na2 = (bi == NA_V);
        ma  = (a < 0) ? -a : a;
        mb  = (b < 0) ? -b : b;
        case (op)
            1:  return !(na1 || na2) && (a == b);
            2:  return na1 || na2 || (a != b);
            3:  return !(na1 || na2) && (a <  b);
            4:  return !(na1 || na2) && (a <= b);
            5:  return !(na1 || na2) && (a >  b);
            6:  return !(na1 || na2) && (a >= b);
            7:  return na1;
            8:  return !na1;
            9:  return (ai & bi) != 0;
            10: return !na1 && (a < 0);
            11: return a == 0;
            12: return !(na1 || na2) && (ma < mb);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drives one element, advances the model, and checks the result one cycle later.
    task automatic step(input int a, input int b, input logic [7:0] c,
                        input string tag, input bit has_exp, input bit exp_v);
        bit r, acc, e;
        @(negedge clk);
        in1 = a;
        in2 = b;
        cmd = c;
        r = model_raw(int'(c[3:0]), a, b) ^ c[6];
        case (c[5:4])
            2'b01: begin
                acc   = c[7] ? 1'b0 : m_any;
                m_any = acc | r;
                e     = m_any;
            end
            2'b10: begin
                acc   = c[7] ? 1'b1 : m_all;
                m_all = acc & r;
                e     = m_all;
            end
            default: e = r;
        endcase
        @(posedge clk);
        #1;
        check(tag, out, has_exp ? exp_v : e);
        $display("step %s in1=%0d in2=%0d cmd=%h out=%b exp=%b", tag, a, b, c, out,
                 has_exp ? exp_v : e);
    endtask

    function automatic int pick_operand();
        case ($urandom_range(0, 5))
            0:       return NA_V;
            1:       return 0;
            2:       return int'($urandom_range(0, 10)) - 5;
            3:       return int'($urandom);
            4:       return 32'h7fff_ffff;
            default: return int'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        int a, b;
        logic [7:0] c;

        // Reset held with an EQ-true element on the inputs.
        reset = 1'b0;
        in1 = 5; in2 = 5; cmd = mk(4'd1, 2'b00, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", out, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", out, 1'b1);

        // Signed compares
        step(-3, 7, mk(4'd3, 2'b00, 0, 0), "lt",  1, 1'b1);
        step(-3, 7, mk(4'd4, 2'b00, 0, 0), "le",  1, 1'b1);
        step(-3, 7, mk(4'd5, 2'b00, 0, 0), "gt",  1, 1'b0);
        step(-3, 7, mk(4'd6, 2'b00, 0, 0), "ge",  1, 1'b0);
        step(-3, 7, mk(4'd1, 2'b00, 0, 0), "eq",  1, 1'b0);
        step(-3, 7, mk(4'd2, 2'b00, 0, 0), "ne",  1, 1'b1);
        step(-3, -3, mk(4'd1, 2'b00, 0, 0), "eq_same", 1, 1'b1);
        step(-3, -3, mk(4'd4, 2'b00, 0, 0), "le_same", 1, 1'b1);

        // NA handling
        step(NA_V, 0, mk(4'd1, 2'b00, 0, 0), "na_eq",    1, 1'b0);
        step(NA_V, 0, mk(4'd3, 2'b00, 0, 0), "na_lt",    1, 1'b0);
        step(NA_V, 0, mk(4'd2, 2'b00, 0, 0), "na_ne",    1, 1'b1);
        step(NA_V, 0, mk(4'd7, 2'b00, 0, 0), "na_isna",  1, 1'b1);
        step(NA_V, 0, mk(4'd8, 2'b00, 0, 0), "na_notna", 1, 1'b0);
        step(NA_V, 0, mk(4'd1, 2'b00, 1, 0), "na_eq_inv", 1, 1'b1);

        // Bitwise, sign, zero, magnitude
        step(6, 3,  mk(4'd9,  2'b00, 0, 0), "andnz_1", 1, 1'b1);
        step(4, 3,  mk(4'd9,  2'b00, 0, 0), "andnz_0", 1, 1'b0);
        step(-9, 5, mk(4'd12, 2'b00, 0, 0), "abslt",   1, 1'b0);
        step(-9, 5, mk(4'd10, 2'b00, 0, 0), "neg",     1, 1'b1);
        step(0, 5,  mk(4'd11, 2'b00, 0, 0), "zero",    1, 1'b1);

        // ANY reduction over GT
        step(1, 2, mk(4'd5, 2'b01, 0, 1), "any0", 1, 1'b0);
        step(5, 2, mk(4'd5, 2'b01, 0, 0), "any1", 1, 1'b1);
        step(0, 2, mk(4'd5, 2'b01, 0, 0), "any2", 1, 1'b1);
        step(0, 2, mk(4'd5, 2'b01, 0, 1), "any_restart", 1, 1'b0);
        step(5, 2, mk(4'd5, 2'b01, 0, 0), "any_set", 1, 1'b1);

        // ALL reduction over GE
        step(3, 1, mk(4'd6, 2'b10, 0, 1), "all0", 1, 1'b1);
        step(2, 2, mk(4'd6, 2'b10, 0, 0), "all1", 1, 1'b1);
        step(1, 2, mk(4'd6, 2'b10, 0, 0), "all2", 1, 1'b0);
        step(9, 0, mk(4'd6, 2'b10, 0, 0), "all3", 1, 1'b0);
        step(4, 4, mk(4'd1, 2'b00, 0, 1), "none_between", 1, 1'b1);
        step(9, 0, mk(4'd6, 2'b10, 0, 0), "all_held", 1, 1'b0);
        step(9, 0, mk(4'd13, 2'b00, 0, 0), "reserved13", 1, 1'b0);
        step(0, 2, mk(4'd5, 2'b01, 0, 0), "any_untouched", 1, 1'b1);

        // Asynchronous reset mid-cycle, then reductions restart from their identities.
        step(5, 5, mk(4'd1, 2'b00, 0, 0), "pre_async", 1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", out, 1'b0);
        m_any = 1'b0;
        m_all = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step(9, 0, mk(4'd6, 2'b10, 0, 0), "all_post_reset", 1, 1'b1);
        step(0, 2, mk(4'd5, 2'b01, 0, 0), "any_post_reset", 1, 1'b0);

        // Random stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            a = pick_operand();
            b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
            c = 8'($urandom);
            step(a, b, c, "rand", 0, 1'b0);
        end

        step(0, 0, 8'h00, "idle", 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
